// File: rtl/lk_grad_pkg.sv
// Shared types, widths and small helpers for the LK spatial-gradient stage.
package lk_grad_pkg;

  localparam int PIX_WIDTH        = 9;
  localparam int DEC_WIDTH        = 15;
  localparam int PIX_INTERP_WIDTH = PIX_WIDTH + DEC_WIDTH + 2;
  localparam int MAX_DIM          = 31;
  localparam int GRAD_WIDTH       = PIX_INTERP_WIDTH + 1;
  localparam int DIM_WIDTH        = 5;
  localparam int SLOT_WIDTH       = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic signed [GRAD_WIDTH-1:0]       grad_t;
  typedef logic        [PIX_INTERP_WIDTH-1:0] pix_t;
  typedef logic        [DIM_WIDTH-1:0]        dim_t;
  typedef logic        [SLOT_WIDTH-1:0]       slot_t;

  // Row slot that follows s in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic slot_t slot_next(input slot_t s);
    case (s)
      2'd0:    slot_next = 2'd1;
      2'd1:    slot_next = 2'd2;
      2'd2:    slot_next = 2'd0;
      default: slot_next = 2'd0;
    endcase
  endfunction

  // Row slot that precedes s in the rotation (the row above).
  function automatic slot_t slot_prev(input slot_t s);
    case (s)
      2'd0:    slot_prev = 2'd2;
      2'd1:    slot_prev = 2'd0;
      2'd2:    slot_prev = 2'd1;
      default: slot_prev = 2'd0;
    endcase
  endfunction

  // Unsigned pixels are zero-extended by one bit, so a - b can never overflow.
  function automatic grad_t grad_sub(input pix_t a, input pix_t b);
    grad_sub = $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage

// File: rtl/lk_spatial_gradient_if.sv
// Pixel-in / gradient-out bus of the spatial-gradient stage.
interface lk_spatial_gradient_if;
  import lk_grad_pkg::*;

  dim_t  win_dim;
  pix_t  pix_interp;
  logic  pix_interp_val;
  grad_t grad_x;
  grad_t grad_y;
  pix_t  grad_pix;
  logic  grad_val;
  logic  grad_last;
  logic  win_done;

  modport master (
    output win_dim, pix_interp, pix_interp_val,
    input  grad_x, grad_y, grad_pix, grad_val, grad_last, win_done
  );

  modport slave (
    input  win_dim, pix_interp, pix_interp_val,
    output grad_x, grad_y, grad_pix, grad_val, grad_last, win_done
  );

endinterface

// File: rtl/lk_grad_chk.sv
// Simulation-only legality checks for the spatial-gradient stage.
module lk_grad_chk
  import lk_grad_pkg::*;
(
  input logic   clk,
  input logic   reset,
  input state_t state_i,
  input logic   val_i,
  input dim_t   win_dim_i
);

  // A window may not request a side larger than the row buffer holds.
  a_dim_legal: assert property (@(posedge clk) disable iff (!reset)
    (val_i && (state_i == IDLE)) |-> (32'(win_dim_i) <= 32'(MAX_DIM)));

endmodule

// File: rtl/lk_grad_row_buf.sv
// Three-row circular pixel store: one write port, four combinational reads.
module lk_grad_row_buf
  import lk_grad_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  slot_t wr_slot_i,
  input  dim_t  wr_col_i,
  input  pix_t  wr_data_i,
  input  slot_t rd_slot_i [0:3],
  input  dim_t  rd_col_i  [0:3],
  output pix_t  rd_data_o [0:3]
);

  pix_t mem_q [0:2][0:MAX_DIM-1];

  // Store each accepted pixel at its (row slot, column); contents need no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
    end
  end

  // Four independent asynchronous read ports.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_data_o[i] = mem_q[rd_slot_i[i]][rd_col_i[i]];
    end
  end

endmodule

// File: rtl/lk_spatial_gradient.sv
// Central-difference Ix/Iy over a row-major window stream, paired with the centre pixel.
module lk_spatial_gradient
  import lk_grad_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  lk_spatial_gradient_if.slave bus
);

  state_t state_q, state_d;
  dim_t   dim_q, dim_d;
  dim_t   row_q, row_d;
  dim_t   col_q, col_d;
  slot_t  slot_q, slot_d;

  // Position of the current beat; in IDLE the beat is always pixel (0,0).
  dim_t  dim_eff_s, row_eff_s, col_eff_s, dim_m1_s, dim_m2_s;
  slot_t slot_eff_s;
  logic  beat_s, row_end_s, last_s, emit_s, glast_s;

  slot_t rd_slot_s [0:3];
  dim_t  rd_col_s  [0:3];
  pix_t  rd_data_s [0:3];

  grad_t grad_x_q, grad_y_q;
  pix_t  grad_pix_q;
  logic  grad_val_q, grad_last_q, win_done_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dim_q   <= 5'd0;
      row_q   <= 5'd0;
      col_q   <= 5'd0;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      row_q   <= row_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
    end
  end

  // Advance column/row/slot on each accepted beat; return to IDLE after the last one.
  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    row_d   = row_q;
    col_d   = col_q;
    slot_d  = slot_q;
    if (beat_s) begin
      if (last_s) begin
        state_d = IDLE;
        row_d   = 5'd0;
        col_d   = 5'd0;
        slot_d  = 2'd0;
      end else if (row_end_s) begin
        state_d = RUN;
        dim_d   = dim_eff_s;
        row_d   = row_eff_s + 5'd1;
        col_d   = 5'd0;
        slot_d  = slot_next(slot_eff_s);
      end else begin
        state_d = RUN;
        dim_d   = dim_eff_s;
        row_d   = row_eff_s;
        col_d   = col_eff_s + 5'd1;
        slot_d  = slot_eff_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Decode the beat position, window end and emission conditions.
  always_comb begin
    dim_eff_s  = dim_q;
    row_eff_s  = row_q;
    col_eff_s  = col_q;
    slot_eff_s = slot_q;
    beat_s     = 1'b0;
    case (state_q)
      IDLE: begin
        dim_eff_s  = bus.win_dim;
        row_eff_s  = 5'd0;
        col_eff_s  = 5'd0;
        slot_eff_s = 2'd0;
        beat_s     = bus.pix_interp_val && (bus.win_dim != 5'd0);
      end
      RUN: begin
        beat_s = bus.pix_interp_val;
      end
      default: begin
        beat_s = 1'b0;
      end
    endcase
    dim_m1_s  = dim_eff_s - 5'd1;
    dim_m2_s  = dim_eff_s - 5'd2;
    row_end_s = (col_eff_s == dim_m1_s);
    last_s    = beat_s && (row_eff_s == dim_m1_s) && row_end_s;
    emit_s    = beat_s && (row_eff_s >= 5'd2) && (col_eff_s >= 5'd1) && (col_eff_s <= dim_m2_s);
    glast_s   = emit_s && (row_eff_s == dim_m1_s) && (col_eff_s == dim_m2_s);
  end

  // Neighbours of interior pixel (r-1,c) while pixel (r,c) arrives: left, right, up, centre.
  always_comb begin
    rd_slot_s[0] = slot_prev(slot_eff_s);
    rd_col_s[0]  = col_eff_s - 5'd1;
    rd_slot_s[1] = slot_prev(slot_eff_s);
    rd_col_s[1]  = col_eff_s + 5'd1;
    rd_slot_s[2] = slot_prev(slot_prev(slot_eff_s));
    rd_col_s[2]  = col_eff_s;
    rd_slot_s[3] = slot_prev(slot_eff_s);
    rd_col_s[3]  = col_eff_s;
  end

  lk_grad_row_buf u_row_buf (
    .clk       (clk),
    .we_i      (beat_s),
    .wr_slot_i (slot_eff_s),
    .wr_col_i  (col_eff_s),
    .wr_data_i (bus.pix_interp),
    .rd_slot_i (rd_slot_s),
    .rd_col_i  (rd_col_s),
    .rd_data_o (rd_data_s)
  );

  // Registered outputs; data fields hold between gradients.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grad_x_q    <= '0;
      grad_y_q    <= '0;
      grad_pix_q  <= '0;
      grad_val_q  <= 1'b0;
      grad_last_q <= 1'b0;
      win_done_q  <= 1'b0;
    end else begin
      grad_val_q  <= emit_s;
      grad_last_q <= glast_s;
      win_done_q  <= last_s;
      if (emit_s) begin
        grad_x_q   <= grad_sub(rd_data_s[1], rd_data_s[0]);
        grad_y_q   <= grad_sub(bus.pix_interp, rd_data_s[2]);
        grad_pix_q <= rd_data_s[3];
      end
    end
  end

  assign bus.grad_x    = grad_x_q;
  assign bus.grad_y    = grad_y_q;
  assign bus.grad_pix  = grad_pix_q;
  assign bus.grad_val  = grad_val_q;
  assign bus.grad_last = grad_last_q;
  assign bus.win_done  = win_done_q;

  lk_grad_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .state_i   (state_q),
    .val_i     (bus.pix_interp_val),
    .win_dim_i (bus.win_dim)
  );

endmodule

// File: tb/tb_lk_spatial_gradient.sv
// Directed bench for lk_spatial_gradient: ramps, gaps, back-to-back, reset abort, extremes.
module tb_lk_spatial_gradient;
  import lk_grad_pkg::*;

  localparam int PMAX = (1 << PIX_INTERP_WIDTH) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   got_pix [$];

  lk_spatial_gradient_if bus ();

  lk_spatial_gradient dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pixel patterns: 0 ramp 10r+c, 1 descending 100-(10r+c), 2 max in col 2, 3 max in col 0.
  function automatic int pval(input int mode, input int r, input int c);
    case (mode)
      0:       return 10 * r + c;
      1:       return 100 - (10 * r + c);
      2:       return (c == 2) ? PMAX : 0;
      default: return (c == 0) ? PMAX : 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One input beat for pixel (r,c); outputs sampled 1 ns after the consuming edge.
  task automatic beat(input int dim, input int mode, input int r, input int c, input logic [4:0] wd);
    logic  emit;
    grad_t ex, ey;
    @(negedge clk);
    bus.win_dim        = wd;
    bus.pix_interp     = pix_t'(pval(mode, r, c));
    bus.pix_interp_val = 1'b1;
    @(posedge clk);
    #1;
    emit = (r >= 2) && (c >= 1) && (c <= dim - 2);
    check("grad_val",  32'(bus.grad_val),  32'(emit));
    check("grad_last", 32'(bus.grad_last), 32'(emit && (r == dim - 1) && (c == dim - 2)));
    check("win_done",  32'(bus.win_done),  32'((r == dim - 1) && (c == dim - 1)));
    if (emit) begin
      ex = grad_t'(pval(mode, r - 1, c + 1) - pval(mode, r - 1, c - 1));
      ey = grad_t'(pval(mode, r, c) - pval(mode, r - 2, c));
      check("grad_x",   32'(bus.grad_x),   32'(ex));
      check("grad_y",   32'(bus.grad_y),   32'(ey));
      check("grad_pix", 32'(bus.grad_pix), 32'(pval(mode, r - 1, c)));
      got_pix.push_back(int'(bus.grad_pix));
    end
  endtask

  // Idle cycles: no gradient and no window-done may appear.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_interp_val = 1'b0;
      bus.win_dim        = 5'd9;
      @(posedge clk);
      #1;
      check("idle_val",  32'(bus.grad_val), 32'd0);
      check("idle_done", 32'(bus.win_done), 32'd0);
    end
  endtask

  // Full window; mid-window win_dim is deliberately wrong to prove it is ignored.
  task automatic window(input int dim, input int mode, input int maxgap);
    got_pix.delete();
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        beat(dim, mode, r, c, (r == 0 && c == 0) ? 5'(dim) : 5'(3 + r));
        if (maxgap > 0 && !(r == dim - 1 && c == dim - 1)) begin
          idle(int'($urandom_range(0, maxgap)));
        end
      end
    end
  endtask

  initial begin
    int exp5 [9] = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
    int exp4 [4] = '{89, 88, 79, 78};

    bus.win_dim        = 5'd0;
    bus.pix_interp     = '0;
    bus.pix_interp_val = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_val",  32'(bus.grad_val),  32'd0);
    check("rst_last", 32'(bus.grad_last), 32'd0);
    check("rst_done", 32'(bus.win_done),  32'd0);
    check("rst_x",    32'(bus.grad_x),    32'd0);
    check("rst_pix",  32'(bus.grad_pix),  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // win_dim=0 beat is ignored: nothing happens, next window still starts cleanly.
    @(negedge clk);
    bus.win_dim        = 5'd0;
    bus.pix_interp_val = 1'b1;
    idle(1);

    // win_dim=3 ramp: single gradient 2/20/11.
    window(3, 0, 0);
    check("w3_count", 32'(got_pix.size()), 32'd1);
    check("w3_gx",    32'(bus.grad_x),     32'd2);
    check("w3_gy",    32'(bus.grad_y),     32'd20);
    check("w3_pix",   32'(bus.grad_pix),   32'd11);
    idle(2);

    // win_dim=5 ramp with random gaps.
    window(5, 0, 3);
    check("w5_count", 32'(got_pix.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check("w5_order", 32'(got_pix[i]), 32'(exp5[i]));
    end
    idle(1);

    // win_dim=4 descending: negative gradients.
    window(4, 1, 0);
    check("w4_count", 32'(got_pix.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("w4_order", 32'(got_pix[i]), 32'(exp4[i]));
    end
    check("w4_gx", 32'(bus.grad_x), 32'(grad_t'(-2)));
    check("w4_gy", 32'(bus.grad_y), 32'(grad_t'(-20)));

    // win_dim=2 then win_dim=3 with no bubble.
    window(2, 0, 0);
    check("w2_count", 32'(got_pix.size()), 32'd0);
    window(3, 0, 0);
    check("b2b_count", 32'(got_pix.size()), 32'd1);
    check("b2b_pix",   32'(bus.grad_pix),   32'd11);
    idle(1);

    // Abort a win_dim=4 window after 6 beats with reset.
    got_pix.delete();
    for (int i = 0; i < 6; i++) begin
      beat(4, 0, i / 4, i % 4, 5'd4);
    end
    @(negedge clk);
    bus.pix_interp_val = 1'b0;
    reset              = 1'b0;
    #1;
    check("abort_val",  32'(bus.grad_val),  32'd0);
    check("abort_last", 32'(bus.grad_last), 32'd0);
    check("abort_done", 32'(bus.win_done),  32'd0);
    check("abort_x",    32'(bus.grad_x),    32'd0);
    check("abort_pix",  32'(bus.grad_pix),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    window(3, 0, 0);
    check("post_rst_count", 32'(got_pix.size()), 32'd1);
    idle(1);

    // Full-scale pixels next to zero.
    window(3, 2, 0);
    check("max_pos_gx", 32'(bus.grad_x), 32'(grad_t'(PMAX)));
    window(3, 3, 0);
    check("max_neg_gx", 32'(bus.grad_x), 32'(grad_t'(-PMAX)));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
